// File: rtl/pixel_timing_gen.sv
// Raster timing generator: free-running h/v counters with an undelayed x/y/valid
// view and a pix_en-clocked pipeline that aligns sync, data enable and colour.
module pixel_timing_gen #(
   parameter int H_ACTIVE   = 1280,
   parameter int H_FP       = 48,
   parameter int H_SYNC     = 112,
   parameter int H_BP       = 248,
   parameter int V_ACTIVE   = 1024,
   parameter int V_FP       = 1,
   parameter int V_SYNC     = 3,
   parameter int V_BP       = 38,
   parameter int PIPE_DELAY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pix_en,
   input  logic [7:0]  r,
   input  logic [7:0]  g,
   input  logic [7:0]  b,
   output logic [10:0] x,
   output logic [9:0]  y,
   output logic        valid,
   output logic        vsync,
   output logic        frame_start,
   output logic        dvi_hsync,
   output logic        dvi_vsync,
   output logic        dvi_de,
   output logic [7:0]  dvi_r,
   output logic [7:0]  dvi_g,
   output logic [7:0]  dvi_b
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
   localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [10:0]           hcount;
   logic [10:0]           vcount;
   logic                  h_wrap;
   logic                  v_wrap;
   logic                  hsync;
   logic [PIPE_DELAY-1:0] de_pipe;
   logic [PIPE_DELAY-1:0] hs_pipe;
   logic [PIPE_DELAY-1:0] vs_pipe;
   logic [PIPE_DELAY-1:0] de_shift;
   logic [PIPE_DELAY-1:0] hs_shift;
   logic [PIPE_DELAY-1:0] vs_shift;
   logic                  de_tap;

   assign h_wrap = (hcount == H_LAST);
   assign v_wrap = (vcount == V_LAST);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values and simulation matches the synthesized flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         hcount      <= '0;
         vcount      <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= pix_en && h_wrap && v_wrap;
         if (pix_en) begin
            hcount <= h_wrap ? 11'd0 : hcount + 11'd1;
            if (h_wrap)
               vcount <= v_wrap ? 11'd0 : vcount + 11'd1;
         end
      end
   end

   assign x     = hcount;
   assign y     = vcount[9:0];
   assign valid = (hcount < H_ACT) && (vcount < V_ACT);
   assign hsync = !((hcount >= HS_FIRST) && (hcount <= HS_LAST));
   assign vsync = !((vcount >= VS_FIRST) && (vcount <= VS_LAST));

   // Bit 0 of each shifted vector is the undelayed signal, so the tap one stage
   // short of the output degenerates to valid itself when PIPE_DELAY is 1.
   assign de_shift = PIPE_DELAY'({de_pipe, valid});
   assign hs_shift = PIPE_DELAY'({hs_pipe, hsync});
   assign vs_shift = PIPE_DELAY'({vs_pipe, vsync});
   assign de_tap   = de_shift[PIPE_DELAY-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         de_pipe <= '0;
         hs_pipe <= '1;
         vs_pipe <= '1;
         dvi_r   <= 8'd0;
         dvi_g   <= 8'd0;
         dvi_b   <= 8'd0;
      end else if (pix_en) begin
         de_pipe <= de_shift;
         hs_pipe <= hs_shift;
         vs_pipe <= vs_shift;
         dvi_r   <= de_tap ? r : 8'd0;
         dvi_g   <= de_tap ? g : 8'd0;
         dvi_b   <= de_tap ? b : 8'd0;
      end
   end

   assign dvi_de    = de_pipe[PIPE_DELAY-1];
   assign dvi_hsync = hs_pipe[PIPE_DELAY-1];
   assign dvi_vsync = vs_pipe[PIPE_DELAY-1];

endmodule

// File: tb/tb_pixel_timing_gen.sv
// Bench for pixel_timing_gen on a shrunken 32x18 raster, with PIPE_DELAY=2 and
// PIPE_DELAY=1 instances checked against a position-arithmetic reference model.
module tb_pixel_timing_gen;

   localparam int HA = 16, HF = 4, HS = 6, HB = 6;
   localparam int VA = 10, VF = 1, VS = 3, VB = 4;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FT = HT * VT;

   logic        clk = 1'b0;
   logic        reset;
   logic        pix_en;
   logic [7:0]  r2, g2, b2, r1, g1, b1;
   logic [10:0] x2, x1;
   logic [9:0]  y2, y1;
   logic        valid2, vsync2, fs2, dhs2, dvs2, dde2;
   logic        valid1, vsync1, fs1, dhs1, dvs1, dde1;
   logic [7:0]  dr2, dg2, db2, dr1, dg1, db1;

   int total = 0;
   int bad   = 0;
   int adv   = 0;
   bit fs_exp = 1'b0;

   always #5 clk = ~clk;

   pixel_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .PIPE_DELAY(2)) dut2 (
      .clk(clk), .reset(reset), .pix_en(pix_en), .r(r2), .g(g2), .b(b2),
      .x(x2), .y(y2), .valid(valid2), .vsync(vsync2), .frame_start(fs2),
      .dvi_hsync(dhs2), .dvi_vsync(dvs2), .dvi_de(dde2),
      .dvi_r(dr2), .dvi_g(dg2), .dvi_b(db2));

   pixel_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .PIPE_DELAY(1)) dut1 (
      .clk(clk), .reset(reset), .pix_en(pix_en), .r(r1), .g(g1), .b(b1),
      .x(x1), .y(y1), .valid(valid1), .vsync(vsync1), .frame_start(fs1),
      .dvi_hsync(dhs1), .dvi_vsync(dvs1), .dvi_de(dde1),
      .dvi_r(dr1), .dvi_g(dg1), .dvi_b(db1));

   // Reference model: pixel k (k advances since reset) sits at raster position k mod FT.
   function automatic int hp(int k); return k % HT; endfunction
   function automatic int vp(int k); return (k / HT) % VT; endfunction
   function automatic logic vld(int k); return (hp(k) < HA) && (vp(k) < VA); endfunction
   function automatic logic hsy(int k);
      return !((hp(k) >= HA + HF) && (hp(k) < HA + HF + HS));
   endfunction
   function automatic logic vsy(int k);
      return !((vp(k) >= VA + VF) && (vp(k) < VA + VF + VS));
   endfunction
   function automatic logic [23:0] colour(int k);
      return {8'(hp(k)), 8'(vp(k)), 8'(hp(k) * 7 + vp(k))};
   endfunction
   function automatic logic [26:0] dvi_exp(int m, int p);
      int k;
      if (m < p) return {1'b0, 1'b1, 1'b1, 24'd0};
      k = m - p;
      return {vld(k), hsy(k), vsy(k), vld(k) ? colour(k) : 24'd0};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (adv=%0d t=%0t)", name, act, exp, adv, $time);
      end
   endtask

   task automatic check_model();
      logic [63:0] core_exp;
      core_exp = 64'({11'(hp(adv)), 10'(vp(adv)), vld(adv), vsy(adv), fs_exp});
      check("core_p2", 64'({x2, y2, valid2, vsync2, fs2}), core_exp);
      check("core_p1", 64'({x1, y1, valid1, vsync1, fs1}), core_exp);
      check("dvi_p2", 64'({dde2, dhs2, dvs2, dr2, dg2, db2}), 64'(dvi_exp(adv, 2)));
      check("dvi_p1", 64'({dde1, dhs1, dvs1, dr1, dg1, db1}), 64'(dvi_exp(adv, 1)));
   endtask

   // Drives one clock of stimulus from a negedge, updates the model, checks at the next negedge.
   task automatic cycle(input logic en, input logic rst);
      reset  = rst;
      pix_en = en;
      if (en && !rst) begin
         {r2, g2, b2} = (adv >= 1) ? colour(adv - 1) : 24'($urandom);
         {r1, g1, b1} = colour(adv);
      end else begin
         {r2, g2, b2} = 24'($urandom);
         {r1, g1, b1} = 24'($urandom);
      end
      @(posedge clk);
      if (rst) begin
         adv    = 0;
         fs_exp = 1'b0;
      end else if (en) begin
         adv++;
         fs_exp = (adv % FT == 0);
      end else begin
         fs_exp = 1'b0;
      end
      @(negedge clk);
      check_model();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b0);
   endtask

   typedef struct {
      int          n;
      logic [10:0] x;
      logic [9:0]  y;
      logic        valid;
      logic        vsync;
   } vec_t;

   vec_t tbl[13];

   initial begin
      int cnt_a, cnt_b, first;

      tbl[0]  = '{0,   11'd0,  10'd0,  1'b1, 1'b1};
      tbl[1]  = '{15,  11'd15, 10'd0,  1'b1, 1'b1};
      tbl[2]  = '{16,  11'd16, 10'd0,  1'b0, 1'b1};
      tbl[3]  = '{31,  11'd31, 10'd0,  1'b0, 1'b1};
      tbl[4]  = '{32,  11'd0,  10'd1,  1'b1, 1'b1};
      tbl[5]  = '{303, 11'd15, 10'd9,  1'b1, 1'b1};
      tbl[6]  = '{304, 11'd16, 10'd9,  1'b0, 1'b1};
      tbl[7]  = '{320, 11'd0,  10'd10, 1'b0, 1'b1};
      tbl[8]  = '{352, 11'd0,  10'd11, 1'b0, 1'b0};
      tbl[9]  = '{447, 11'd31, 10'd13, 1'b0, 1'b0};
      tbl[10] = '{448, 11'd0,  10'd14, 1'b0, 1'b1};
      tbl[11] = '{575, 11'd31, 10'd17, 1'b0, 1'b1};
      tbl[12] = '{576, 11'd0,  10'd0,  1'b1, 1'b1};

      reset  = 1'b1;
      pix_en = 1'b0;
      {r2, g2, b2, r1, g1, b1} = '0;
      @(negedge clk);
      cycle(1'b0, 1'b1);
      check("reset_state", 64'({x2, y2, valid2, vsync2, fs2, dde2, dhs2, dvs2, dr2, dg2, db2}),
            64'({11'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 24'd0}));

      for (int i = 0; i < 13; i++) begin
         cycle(1'b0, 1'b1);
         run(tbl[i].n);
         check($sformatf("tbl_n%0d", tbl[i].n), 64'({x2, y2, valid2, vsync2}),
               64'({tbl[i].x, tbl[i].y, tbl[i].valid, tbl[i].vsync}));
      end

      // One line: valid width, delayed hsync width and position, then row 1.
      cycle(1'b0, 1'b1);
      cnt_a = 0; cnt_b = 0; first = -1;
      for (int i = 1; i <= HT + 2; i++) begin
         cnt_a += (i <= HT) ? int'(valid2) : 0;
         cycle(1'b1, 1'b0);
         if (!dhs2) begin
            cnt_b++;
            if (first < 0) first = i;
         end
         if (i == HT) check("line_end_xy", 64'({x2, y2}), 64'({11'd0, 10'd1}));
      end
      check("valid_per_line", 64'(cnt_a), 64'(HA));
      check("hsync_width", 64'(cnt_b), 64'(HS));
      check("hsync_start", 64'(first), 64'(HA + HF + 2));

      // One frame: vsync low for VS full lines, exactly one frame_start at the wrap.
      cycle(1'b0, 1'b1);
      cnt_a = 0; cnt_b = 0;
      for (int i = 0; i < FT; i++) begin
         cnt_a += int'(!vsync2);
         cycle(1'b1, 1'b0);
         cnt_b += int'(fs2);
      end
      check("vsync_low_adv", 64'(cnt_a), 64'(VS * HT));
      check("frame_start_cnt", 64'(cnt_b), 64'd1);
      cycle(1'b0, 1'b0);
      check("frame_start_single", 64'(fs2), 64'd0);

      // Alternating pix_en: only the enabled cycles advance.
      cycle(1'b0, 1'b1);
      for (int i = 0; i < 40; i++) cycle(i[0] == 1'b0, 1'b0);
      check("toggle_x", 64'(x2), 64'd20);

      // Mid-frame reset restarts at (0,0) without frame_start.
      cycle(1'b0, 1'b1);
      run(7 * HT + 5);
      cycle(1'b1, 1'b1);
      check("midframe_reset", 64'({x2, y2, valid2, dde2, fs2}),
            64'({11'd0, 10'd0, 1'b1, 1'b0, 1'b0}));
      run(FT - 1);
      cycle(1'b1, 1'b1);
      check("reset_at_wrap_no_fs", 64'({fs2, fs1}), 64'd0);

      // Last active pixel of the frame: valid stays low until the (0,0) wrap.
      run((VA - 1) * HT + HA - 1);
      check("last_active_valid", 64'(valid2), 64'd1);
      cnt_a = 0;
      for (int i = 0; i < FT - ((VA - 1) * HT + HA); i++) begin
         cycle(1'b1, 1'b0);
         cnt_a += int'(valid2);
      end
      check("blank_no_valid", 64'(cnt_a), 64'd0);
      cycle(1'b1, 1'b0);
      check("valid_after_wrap", 64'({x2, y2, valid2}), 64'({11'd0, 10'd0, 1'b1}));

      // Random pix_en with occasional resets.
      for (int i = 0; i < 3000; i++)
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 499) == 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pixel_timing_gen.md
PIXEL_TIMING_GEN -- requirements
Module: pixel_timing_gen

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameter H_ACTIVE, default 1280, SHALL set the visible pixels per line.
REQ-003 Parameter H_FP, default 48, SHALL set the horizontal front porch in pixels.
REQ-004 Parameter H_SYNC, default 112, SHALL set the hsync pulse width in pixels.
REQ-005 Parameter H_BP, default 248, SHALL set the horizontal back porch in pixels; the line total is 1688.
REQ-006 Parameter V_ACTIVE, default 1024, SHALL set the visible lines per frame.
REQ-007 Parameter V_FP, default 1, SHALL set the vertical front porch in lines.
REQ-008 Parameter V_SYNC, default 3, SHALL set the vsync pulse width in lines.
REQ-009 Parameter V_BP, default 38, SHALL set the vertical back porch in lines; the frame total is 1066.
REQ-010 Parameter PIPE_DELAY, default 2, range 1..8, SHALL set the pixel-advance latency from x/y issue to the DVI outputs.
REQ-011 clk, input, 1 bit: system clock.
REQ-012 reset, input, 1 bit: synchronous active-high reset.
REQ-013 pix_en, input, 1 bit: pixel advance strobe; all counters and delay stages move only when it is 1.
REQ-014 r, g, b, inputs, 8 bits each: pixel colour returned by the display pipeline.
REQ-015 x, output, 11 bits: current column (0..1279 when valid).
REQ-016 y, output, 10 bits: current row (0..1023 when valid).
REQ-017 valid, output, 1 bit: the current x/y lies in the active area.
REQ-018 vsync, output, 1 bit, active low: undelayed vertical sync, low only during the vsync pulse lines.
REQ-019 frame_start, output, 1 bit: single-cycle pulse when the counters wrap to (0,0).
REQ-020 dvi_hsync and dvi_vsync, outputs, 1 bit each, active low: sync signals aligned to dvi_rgb.
REQ-021 dvi_de, output, 1 bit: data enable aligned to dvi_rgb.
REQ-022 dvi_r, dvi_g, dvi_b, outputs, 8 bits each: registered pixel colour.

Function
REQ-023 hcount (11 bits) SHALL increment on each pix_en cycle and wrap from 1687 to 0; vcount (11 bits) SHALL increment when hcount wraps, and itself wrap from 1065 to 0.
REQ-024 When pix_en is 0, all counters, delay stages and dvi_* outputs SHALL hold their values.
REQ-025 x SHALL equal hcount[10:0] and y SHALL equal vcount[9:0]; both are meaningful only when valid is 1.
REQ-026 valid SHALL be 1 iff hcount < 1280 and vcount < 1024, decoded from the registered counters with no added latency.
REQ-027 The internal hsync SHALL be low iff 1328 <= hcount <= 1439.
REQ-028 vsync SHALL be low iff 1025 <= vcount <= 1027, for the full lines, independent of hcount.
REQ-029 frame_start SHALL be 1 for exactly one clk on the cycle after the pix_en advance that moves the counters from (1687,1065) to (0,0).
REQ-030 valid, hsync and vsync SHALL pass through a PIPE_DELAY-stage shift register clocked on pix_en; its outputs drive dvi_de, dvi_hsync and dvi_vsync.
REQ-031 dvi_r, dvi_g and dvi_b SHALL register r, g and b on each pix_en cycle when the last-but-one stage of the de pipe is 1; otherwise they SHALL register 0.
REQ-032 Colour returned PIPE_DELAY-1 advances after an x/y issue SHALL appear on dvi_rgb together with that pixel's dvi_de.
REQ-033 Behaviour at parameter extremes (PIPE_DELAY=1) SHALL keep the sync, de and colour outputs mutually aligned.

Reset
REQ-034 reset SHALL clear hcount, vcount and all delay stages, overriding pix_en.
REQ-035 After reset: x=0, y=0, valid=1, vsync=1, frame_start=0, dvi_de=0, dvi_hsync=1, dvi_vsync=1, dvi_rgb=0.
REQ-036 A reset asserted mid-frame SHALL restart the frame at (0,0) on the next cycle, and SHALL NOT emit frame_start.

Verification
REQ-037 pix_en held at 1 for 1688 cycles after reset -> valid high for 1280 cycles, hsync low for exactly 112 cycles starting at hcount 1328, then y=1.
REQ-038 A full frame of 1688x1066 advances -> vsync low for exactly 3x1688 advances at lines 1025..1027, and one frame_start pulse at the wrap.
REQ-039 pix_en toggling 1,0,1,0 -> counters and dvi_* outputs advance only on the 1 cycles, with the same sequence as with pix_en held at 1.
REQ-040 With PIPE_DELAY=2 and r driven to the low 8 bits of x from the previous advance -> dvi_r equals the column index whenever dvi_de=1, and dvi_r=0 whenever dvi_de=0.
REQ-041 reset asserted at hcount=500, vcount=700 -> next cycle x=0, y=0, valid=1, dvi_de=0, frame_start=0.
REQ-042 At hcount=1279 -> 1280 with vcount=1023 -> valid falls, and the next valid=1 occurs only after the (0,0) wrap.
